rc4_ksa_engine: RTL
===================

# rc4_ksa_engine

Parametrised RC4 key-scheduling engine. It optionally fills the state RAM with the identity permutation, then runs the swap loop (j = j + S[i] + key[i mod key_len]; swap S[i], S[j]) over all 2^ADDR_W entries. Key length is selectable at run time, and the RAM read latency is set by parameter. It sits between the key-search controller and the single-port S-memory, taking over both init and scheduling loops behind one start/done handshake.

## Interface
- KEY_BYTES, 3: maximum key length in bytes (1..32); KEY_W = 8*KEY_BYTES
- ADDR_W, 8: S-memory address width; N = 2^ADDR_W entries, data width fixed 8
- RD_LAT, 2: wait cycles between address launch and rdata sample (0..7)
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; accepted only in IDLE
- do_init  in  1  sampled with start; 1 = fill S[i]=i before scheduling
- key  in  KEY_W  secret key; byte 0 = key[KEY_W-1 -: 8] (MSB first)
- key_len  in  6  bytes of key used; sampled with start
- abort  in  1  level; forces return to IDLE
- mem_addr  out  ADDR_W  S-memory address (registered)
- mem_wdata  out  8  write data (registered)
- mem_wren  out  1  write enable (registered)
- mem_rdata  in  8  read data
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle pulse on completion

## Operation
- Reset values: mem_addr 0, mem_wdata 0, mem_wren 0, busy 0, done 0, i 0, j 0, k 0, state IDLE.
- IDLE: on start, latch key and do_init. Latch key_len; if key_len is 0 or greater than KEY_BYTES, use KEY_BYTES. Clear i, j and k. Next state is FILL if do_init is 1, otherwise RD_I.
- FILL: write mem_addr=i, mem_wdata=i[7:0], mem_wren=1, one entry per cycle. After entry N-1, clear i and go to RD_I.
- RD_I: mem_addr=i, mem_wren=0. Then WAIT_I for RD_LAT cycles (skipped if RD_LAT=0).
- SAV_I: si <= mem_rdata; j <= j + mem_rdata + keybyte(k), mod 2^ADDR_W. Go to RD_J.
- RD_J, WAIT_J, SAV_J: same pattern; sj <= mem_rdata.
- WR_I: write S[i] = sj.
- WR_J: write S[j] = si. Then i <= i+1 and k <= (k+1 == key_len) ? 0 : k+1. No divider is used. If i was N-1, go to DONE; otherwise go to RD_I.
- DONE: pulse done for one cycle, drop busy, go to IDLE. mem_wren is 0 in every state except FILL, WR_I and WR_J.
- i == j: both writes target the same address; the final value is si (the original value), which is correct.
- start while busy: ignored. start in the same cycle as done: ignored; a new start must arrive in IDLE.
- abort, or reset_n low mid-operation: next edge (asynchronous for reset) goes to IDLE with mem_wren=0 and busy=0. No done pulse. S contents are left partially permuted.
- Arithmetic: i and j are ADDR_W bits and wrap naturally. The key byte is zero-extended or truncated to ADDR_W before the add.

## Timing
- Address, data and wren are registered. mem_rdata is sampled on the (RD_LAT+1)th rising edge after the edge that updates mem_addr.
- Swap iteration: 2*RD_LAT + 6 cycles (10 at RD_LAT=2).
- Busy duration: N*(do_init) + N*(2*RD_LAT+6) cycles plus 1 for DONE. At defaults with init: 256 + 2560 + 1 = 2817 cycles.
- busy rises on the edge after the start sample. done is asserted during the single DONE cycle.

## Structure
- Package rc4_pkg holds:
  - state enum (IDLE, FILL, RD_I, WAIT_I, SAV_I, RD_J, WAIT_J, SAV_J, WR_I, WR_J, DONE)
  - default parameter constants
  - key-byte index type
- Sub-module rc4_key_byte_sel: combinational mux returning byte k of the latched key, MSB-first.
- The engine itself is a single FSM with a wait-counter of $clog2(RD_LAT+1) bits.

## Test plan
- Defaults, do_init=1, key=24'h000000, key_len=3: after 4 iterations S[0..5] = 0,1,3,5,4,2. The write trace at i=2 is S[2]=3 then S[3]=2.
- Defaults, key=24'h4B6579 ("Key"), do_init=1: final S must match the software KSA, checked entry by entry. done must occur exactly 2817 cycles after start.
- KEY_BYTES=8 and key_len=5: k cycles 0..4. key_len=0 and key_len=9 both behave identically to key_len=8.
- RD_LAT=0 and RD_LAT=4: memory model with matching latency gives the correct permutation. Iteration lengths are 6 and 14 cycles.
- abort at i=100, and separately reset_n low for 1 cycle: next edge is IDLE with mem_wren=0, busy=0 and no done. A new start then completes normally.
- start pulses while busy: ignored, with no restart and no change to j. do_init=0 on a pre-permuted RAM skips FILL and gives busy = N*(2*RD_LAT+6) + 1 cycles.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-scheduling engine.
package rc4_pkg;

    localparam int unsigned DefKeyBytes = 3;
    localparam int unsigned DefAddrW    = 8;
    localparam int unsigned DefRdLat    = 2;

    // Key byte index: up to 32 key bytes.
    typedef logic [4:0] key_idx_t;
    // Requested key length in bytes as presented with start.
    typedef logic [5:0] key_len_t;

    typedef enum logic [3:0] {
        StIdle,
        StFill,
        StRdI,
        StWaitI,
        StSavI,
        StRdJ,
        StWaitJ,
        StSavJ,
        StWrI,
        StWrJ,
        StDone
    } rc4_state_e;

    // Zero or over-long key lengths fall back to the full key.
    function automatic key_len_t eff_key_len(key_len_t len, int unsigned max_bytes);
        if (len == '0 || 32'(len) > max_bytes) begin
            return key_len_t'(max_bytes);
        end
        return len;
    endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Control handshake plus single-port S-memory bus of the KSA engine.
interface rc4_ksa_engine_if
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = DefKeyBytes,
    parameter int unsigned ADDR_W    = DefAddrW
);

    logic                   start;
    logic                   do_init;
    logic [8*KEY_BYTES-1:0] key;
    key_len_t               key_len;
    logic                   abort;
    logic [ADDR_W-1:0]      mem_addr;
    logic [7:0]             mem_wdata;
    logic                   mem_wren;
    logic [7:0]             mem_rdata;
    logic                   busy;
    logic                   done;

    // Controller side: issues commands and hosts the S-memory.
    modport master (
        output start, do_init, key, key_len, abort, mem_rdata,
        input  mem_addr, mem_wdata, mem_wren, busy, done
    );

    // Engine side.
    modport slave (
        input  start, do_init, key, key_len, abort, mem_rdata,
        output mem_addr, mem_wdata, mem_wren, busy, done
    );

endinterface

// File: rtl/rc4_key_byte_sel.sv
// Selects byte k of the latched key; byte 0 is the most significant byte.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = DefKeyBytes
) (
    input  logic [8*KEY_BYTES-1:0] key_i,
    input  key_idx_t               k_i,
    output logic [7:0]             byte_o
);

    // Plain mux over the key bytes, MSB-first.
    always_comb begin
        byte_o = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k_i == key_idx_t'(b)) begin
                byte_o = key_i[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill, then the swap loop over
// all 2^ADDR_W entries of a single-port S-memory with RD_LAT read wait cycles.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = DefKeyBytes,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned RD_LAT    = DefRdLat
) (
    input logic             clk,
    input logic             reset_n,
    rc4_ksa_engine_if.slave ksa_if
);

    localparam int unsigned KeyW = 8 * KEY_BYTES;
    localparam int unsigned CntW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    rc4_state_e        state_q;
    logic [ADDR_W-1:0] i_q, j_q, mem_addr_q;
    key_idx_t          k_q;
    key_len_t          klen_q;
    logic [KeyW-1:0]   key_q;
    logic [7:0]        si_q, sj_q, mem_wdata_q;
    logic              mem_wren_q, busy_q, done_q;
    logic [CntW-1:0]   wait_q;

    logic [7:0]        key_byte;
    logic [ADDR_W-1:0] key_byte_ext, rdata_ext, j_sum;
    logic [7:0]        i_byte;
    logic [5:0]        k_inc;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_byte_sel (
        .key_i  (key_q),
        .k_i    (k_q),
        .byte_o (key_byte)
    );

    // Key byte and read data are resized to the index width before the add.
    assign key_byte_ext = ADDR_W'(key_byte);
    assign rdata_ext    = ADDR_W'(ksa_if.mem_rdata);
    assign j_sum        = j_q + rdata_ext + key_byte_ext;
    assign i_byte       = 8'(i_q);
    assign k_inc        = {1'b0, k_q} + 6'd1;

    // Main FSM; memory strobes, busy and done are registered with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            klen_q      <= '0;
            key_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            wait_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (ksa_if.abort) begin
            state_q    <= StIdle;
            mem_wren_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_wren_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ksa_if.start) begin
                        key_q   <= ksa_if.key;
                        klen_q  <= eff_key_len(ksa_if.key_len, KEY_BYTES);
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ksa_if.do_init ? StFill : StRdI;
                    end
                end
                StFill: begin
                    mem_addr_q  <= i_q;
                    mem_wdata_q <= i_byte;
                    mem_wren_q  <= 1'b1;
                    // i wraps back to zero after the last entry.
                    i_q         <= i_q + 1'b1;
                    if (i_q == {ADDR_W{1'b1}}) begin
                        state_q <= StRdI;
                    end
                end
                StRdI: begin
                    mem_addr_q <= i_q;
                    wait_q     <= '0;
                    state_q    <= (RD_LAT == 0) ? StSavI : StWaitI;
                end
                StWaitI: begin
                    wait_q <= wait_q + 1'b1;
                    if (wait_q == CntW'(RD_LAT - 1)) begin
                        state_q <= StSavI;
                    end
                end
                StSavI: begin
                    si_q    <= ksa_if.mem_rdata;
                    j_q     <= j_sum;
                    state_q <= StRdJ;
                end
                StRdJ: begin
                    mem_addr_q <= j_q;
                    wait_q     <= '0;
                    state_q    <= (RD_LAT == 0) ? StSavJ : StWaitJ;
                end
                StWaitJ: begin
                    wait_q <= wait_q + 1'b1;
                    if (wait_q == CntW'(RD_LAT - 1)) begin
                        state_q <= StSavJ;
                    end
                end
                StSavJ: begin
                    sj_q    <= ksa_if.mem_rdata;
                    state_q <= StWrI;
                end
                StWrI: begin
                    mem_addr_q  <= i_q;
                    mem_wdata_q <= sj_q;
                    mem_wren_q  <= 1'b1;
                    state_q     <= StWrJ;
                end
                StWrJ: begin
                    // When i == j this second write restores si, which is correct.
                    mem_addr_q  <= j_q;
                    mem_wdata_q <= si_q;
                    mem_wren_q  <= 1'b1;
                    i_q         <= i_q + 1'b1;
                    k_q         <= (k_inc == klen_q) ? '0 : k_inc[4:0];
                    if (i_q == {ADDR_W{1'b1}}) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StRdI;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ksa_if.mem_addr  = mem_addr_q;
    assign ksa_if.mem_wdata = mem_wdata_q;
    assign ksa_if.mem_wren  = mem_wren_q;
    assign ksa_if.busy      = busy_q;
    assign ksa_if.done      = done_q;

endmodule
